audio_in_capture: RTL

// - Capture side of the DE2 audio path: drains ADC samples from the Audio_Controller read handshake
//   (audio_in_available / read_audio_in), folds L/R to one 32-bit sample, buffers it in a FIFO.
// - Presents the buffered samples to a downstream recorder/mixer over a valid/ready stream.
// - Also keeps a decaying 8-bit peak level for the HEX/LED meter.

---
 rtl/audio_in_capture_pkg.sv | 18 +
 rtl/audio_sample_fifo.sv | 61 ++++++
 rtl/audio_in_capture.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/audio_in_capture_pkg.sv
// Shared definitions for the audio capture path: sample width, handshake FSM
// encoding and mono fold select codes.
package audio_in_capture_pkg;

  localparam int AUDIO_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } cap_state_e;

  localparam logic [1:0] MONO_LEFT     = 2'b00;
  localparam logic [1:0] MONO_RIGHT    = 2'b01;
  localparam logic [1:0] MONO_AVG      = 2'b10;
  localparam logic [1:0] MONO_LEFT_ALT = 2'b11;

endpackage

// File: rtl/audio_sample_fifo.sv
// Show-ahead sample FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; a pop on an empty FIFO is ignored.
module audio_sample_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/audio_in_capture.sv
// DE2 audio capture: drains the ADC read handshake, folds L/R to mono, buffers
// samples for a valid/ready consumer and keeps a decaying peak level.
module audio_in_capture
  import audio_in_capture_pkg::*;
#(
  parameter int DATA_W    = AUDIO_W,
  parameter int DEPTH     = 16,
  parameter int DECAY_CYC = 500000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  input  logic [1:0]        mono_sel,
  input  logic              audio_in_available,
  input  logic [DATA_W-1:0] left_channel_audio_in,
  input  logic [DATA_W-1:0] right_channel_audio_in,
  output logic              read_audio_in,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overflow,
  input  logic              clear_overflow,
  output logic [7:0]        peak_level
);

  localparam int DC_W = (DECAY_CYC > 1) ? $clog2(DECAY_CYC) : 1;
  localparam logic [DC_W-1:0] DECAY_LAST = DC_W'(DECAY_CYC - 1);
  localparam int LO_W = DATA_W - 9;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  cap_state_e        state_r;
  cap_state_e        state_s;
  logic              capture_s;
  logic [DATA_W-1:0] sample_s;
  logic [7:0]        m8_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              drop_s;
  logic [DC_W-1:0]   decay_cnt_r;

  assign sample_valid = ~fifo_empty_s;
  assign pop_s        = sample_valid & sample_ready;
  assign drop_s       = capture_s & fifo_full_s & ~pop_s;

  // Handshake next-state: capture in IDLE, then a fixed ACK/GAP tail.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && audio_in_available) begin
          capture_s = 1'b1;
          state_s   = ST_ACK;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_ACK:  state_s = ST_GAP;
      ST_GAP:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and the registered read strobe, high only in ACK.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      read_audio_in <= 1'b0;
    end else begin
      state_r       <= state_s;
      read_audio_in <= (state_s == ST_ACK);
    end
  end

  // Mono fold; halving both operands first keeps the average in range.
  always_comb begin
    case (mono_sel)
      MONO_LEFT, MONO_LEFT_ALT: sample_s = left_channel_audio_in;
      MONO_RIGHT:               sample_s = right_channel_audio_in;
      MONO_AVG:                 sample_s = DATA_W'(($signed(left_channel_audio_in) >>> 1)
                                                 + ($signed(right_channel_audio_in) >>> 1));
      default:                  sample_s = left_channel_audio_in;
    endcase
  end

  // Meter byte of |sample|: for negatives, ~x + 1 only carries into the top
  // byte when every lower bit is zero.
  always_comb begin
    if (sample_s == MOST_NEG) begin
      m8_s = 8'hFF;
    end else if (sample_s[DATA_W-1]) begin
      m8_s = ~sample_s[DATA_W-2 -: 8]
             + {7'd0, (sample_s[LO_W-1:0] == {LO_W{1'b0}})};
    end else begin
      m8_s = sample_s[DATA_W-2 -: 8];
    end
  end

  // Sticky overflow; a drop in the same cycle beats a clear.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      overflow <= 1'b0;
    end else if (drop_s) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Peak meter: a louder capture reloads and restarts the decay period.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      peak_level  <= 8'd0;
      decay_cnt_r <= {DC_W{1'b0}};
    end else if (capture_s && (m8_s > peak_level)) begin
      peak_level  <= m8_s;
      decay_cnt_r <= {DC_W{1'b0}};
    end else if (decay_cnt_r == DECAY_LAST) begin
      decay_cnt_r <= {DC_W{1'b0}};
      if (peak_level != 8'd0) begin
        peak_level <= peak_level - 8'd1;
      end
    end else begin
      decay_cnt_r <= decay_cnt_r + DC_W'(1'b1);
    end
  end

  audio_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .resetn    (resetn),
    .push      (capture_s),
    .push_data (sample_s),
    .pop       (pop_s),
    .head      (sample_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule
